// File: rtl/nand_op_sequencer.sv
// NAND operation sequencer.
// Turns a host page read / page program / block erase / chip reset request into
// the command, address and transfer instructions for the flash interface core.
// Between the last command byte and the first R/B# sample it waits tWB, then
// waits for the ready/busy line to go ready, giving up after a timeout.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a host op, op_ready high
// CMD1   | first command byte (00h / 80h / 60h / FFh)
// ADDR   | address bytes, 5 for read/program, 3 for erase
// XFER   | one page transfer instruction (DIN for program, DOUT for read)
// CMD2   | confirm command byte (30h / 10h / D0h)
// TWB    | fixed tWB wait before R/B# is trusted
// RBWAIT | waiting for synchronized R/B# high, with busy timeout
// DONE   | one-cycle completion pulse, op_err valid
module nand_op_sequencer #(
    parameter int PAGE_BYTES     = 2048,
    parameter int TWB_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [23:0] op_row,
    output logic        op_ready,
    output logic        op_done,
    output logic        op_err,
    output logic [31:0] instr_data,
    output logic        instr_wr,
    input  logic        instr_full,
    output logic [7:0]  byte_data,
    output logic        byte_wr,
    input  logic        byte_full,
    input  logic        iRB_N
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD1   = 3'd1,
        S_ADDR   = 3'd2,
        S_XFER   = 3'd3,
        S_CMD2   = 3'd4,
        S_TWB    = 3'd5,
        S_RBWAIT = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_PROGRAM = 2'b01;
    localparam logic [1:0] OP_ERASE   = 2'b10;
    localparam logic [1:0] OP_RESET   = 2'b11;

    localparam logic [3:0] MODE_CMD  = 4'd1;
    localparam logic [3:0] MODE_ADDR = 4'd2;
    localparam logic [3:0] MODE_DIN  = 4'd3;
    localparam logic [3:0] MODE_DOUT = 4'd4;

    localparam logic [15:0] XFER_COUNT   = 16'(PAGE_BYTES - 1);
    localparam logic [31:0] TWB_LOAD     = 32'(TWB_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  op_kind;
    logic [23:0] row;
    logic [2:0]  addr_idx;
    logic [2:0]  addr_last;
    logic [7:0]  addr_byte;
    logic [7:0]  cmd1_byte;
    logic [7:0]  cmd2_byte;
    logic [31:0] timer;
    logic        timer_zero;
    logic        err_flag;
    logic        ready_en;
    logic        rb_meta;
    logic        rb_sync;
    logic        cmd_ok;
    logic        accept;
    logic        timeout_hit;

    // A command/address byte goes out only when both FIFOs can take it.
    assign cmd_ok      = !instr_full && !byte_full;
    assign op_ready    = ready_en && (state == S_IDLE);
    assign accept      = op_valid && op_ready;
    assign timer_zero  = (timer == 32'd0);
    assign timeout_hit = (state == S_RBWAIT) && !rb_sync && timer_zero;
    assign addr_last   = (op_kind == OP_ERASE) ? 3'd2 : 3'd4;

    // Two-flop synchronizer for the asynchronous ready/busy line; idles ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb_meta <= 1'b1;
            rb_sync <= 1'b1;
        end else begin
            rb_meta <= iRB_N;
            rb_sync <= rb_meta;
        end
    end

    // Holds op_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state decode; every byte step advances only on an actual write.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_CMD1;
            end
            S_CMD1: begin
                if (cmd_ok) state_next = (op_kind == OP_RESET) ? S_TWB : S_ADDR;
            end
            S_ADDR: begin
                if (cmd_ok && (addr_idx == addr_last))
                    state_next = (op_kind == OP_PROGRAM) ? S_XFER : S_CMD2;
            end
            S_XFER: begin
                if (!instr_full)
                    state_next = (op_kind == OP_PROGRAM) ? S_CMD2 : S_DONE;
            end
            S_CMD2: begin
                if (cmd_ok) state_next = S_TWB;
            end
            S_TWB: begin
                if (timer_zero) state_next = S_RBWAIT;
            end
            S_RBWAIT: begin
                if (rb_sync)
                    state_next = (op_kind == OP_READ) ? S_XFER : S_DONE;
                else if (timer_zero)
                    state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Captures the op on accept, steps the address index and records a timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_kind  <= OP_READ;
            row      <= 24'h0;
            addr_idx <= 3'd0;
            err_flag <= 1'b0;
        end else if (accept) begin
            op_kind  <= op_type;
            row      <= op_row;
            addr_idx <= 3'd0;
            err_flag <= 1'b0;
        end else begin
            if ((state == S_ADDR) && cmd_ok && (addr_idx != addr_last))
                addr_idx <= addr_idx + 3'd1;
            if (timeout_hit)
                err_flag <= 1'b1;
        end
    end

    // Shared down-counter: loaded on TWB or RBWAIT entry, stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= 32'd0;
        end else if ((state_next == S_TWB) && (state != S_TWB)) begin
            timer <= TWB_LOAD;
        end else if ((state_next == S_RBWAIT) && (state != S_RBWAIT)) begin
            timer <= TIMEOUT_LOAD;
        end else if (!timer_zero) begin
            timer <= timer - 32'd1;
        end
    end

    // Command and address byte values for the captured op.
    always_comb begin
        cmd1_byte = 8'hFF;
        cmd2_byte = 8'hD0;
        addr_byte = row[23:16];
        case (op_kind)
            OP_READ:    begin cmd1_byte = 8'h00; cmd2_byte = 8'h30; end
            OP_PROGRAM: begin cmd1_byte = 8'h80; cmd2_byte = 8'h10; end
            OP_ERASE:   begin cmd1_byte = 8'h60; cmd2_byte = 8'hD0; end
            default:    begin cmd1_byte = 8'hFF; cmd2_byte = 8'hD0; end
        endcase
        // Read/program lead with two zero column bytes; erase sends row only.
        if (op_kind == OP_ERASE) begin
            case (addr_idx)
                3'd0:    addr_byte = row[7:0];
                3'd1:    addr_byte = row[15:8];
                default: addr_byte = row[23:16];
            endcase
        end else begin
            case (addr_idx)
                3'd0, 3'd1: addr_byte = 8'h00;
                3'd2:       addr_byte = row[7:0];
                3'd3:       addr_byte = row[15:8];
                default:    addr_byte = row[23:16];
            endcase
        end
    end

    // Output decode; data lines stay on the pending step while a FIFO is full.
    always_comb begin
        instr_data = 32'h0;
        instr_wr   = 1'b0;
        byte_data  = 8'hAA;
        byte_wr    = 1'b0;
        op_done    = 1'b0;
        op_err     = 1'b0;
        case (state)
            S_CMD1: begin
                instr_data = {16'h0, 12'h0, MODE_CMD};
                byte_data  = cmd1_byte;
                instr_wr   = cmd_ok;
                byte_wr    = cmd_ok;
            end
            S_ADDR: begin
                instr_data = {16'h0, 12'h0, MODE_ADDR};
                byte_data  = addr_byte;
                instr_wr   = cmd_ok;
                byte_wr    = cmd_ok;
            end
            S_XFER: begin
                instr_data = {XFER_COUNT, 12'h0,
                              (op_kind == OP_PROGRAM) ? MODE_DIN : MODE_DOUT};
                instr_wr   = !instr_full;
            end
            S_CMD2: begin
                instr_data = {16'h0, 12'h0, MODE_CMD};
                byte_data  = cmd2_byte;
                instr_wr   = cmd_ok;
                byte_wr    = cmd_ok;
            end
            S_DONE: begin
                op_done = 1'b1;
                op_err  = err_flag;
            end
            default: begin
                instr_data = 32'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Testbench for nand_op_sequencer: directed op vectors plus stall, timeout
// and mid-operation reset sequences.
module tb_nand_op_sequencer;

    localparam int TWB     = 8;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [23:0] op_row;
    logic        op_ready;
    logic        op_done;
    logic        op_err;
    logic [31:0] instr_data;
    logic        instr_wr;
    logic        instr_full;
    logic [7:0]  byte_data;
    logic        byte_wr;
    logic        byte_full;
    logic        iRB_N;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] iq[$];
    logic [7:0]  bq[$];

    typedef struct {
        logic [1:0]   kind;
        logic [23:0]  row;
        int           rb_low;
        bit           poke;
        logic [63:0]  bytes;
        int           nb;
        logic [255:0] instrs;
        int           ni;
        logic         err;
    } vec_t;

    vec_t vecs[5];

    nand_op_sequencer #(
        .PAGE_BYTES(2048),
        .TWB_CYCLES(TWB),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .op_valid(op_valid),
        .op_type(op_type),
        .op_row(op_row),
        .op_ready(op_ready),
        .op_done(op_done),
        .op_err(op_err),
        .instr_data(instr_data),
        .instr_wr(instr_wr),
        .instr_full(instr_full),
        .byte_data(byte_data),
        .byte_wr(byte_wr),
        .byte_full(byte_full),
        .iRB_N(iRB_N)
    );

    always #5 clk = ~clk;

    // Record every FIFO write, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (instr_wr) iq.push_back(instr_data);
            if (byte_wr)  bq.push_back(byte_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] t, input logic [23:0] r, input bit busy);
        iq.delete();
        bq.delete();
        for (int k = 0; k < 100 && !op_ready; k++) begin
            @(posedge clk); #1;
        end
        check("ready_before_op", op_ready, 1);
        op_type  = t;
        op_row   = r;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_type  = ~t;
        op_row   = 24'hFFFFFF;
        if (busy) iRB_N = 1'b0;
    endtask

    task automatic wait_done(input int rb_low, input bit poke, output logic err, output bit seen);
        seen = 1'b0;
        err  = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (op_done) begin
                seen = 1'b1;
                err  = op_err;
                break;
            end
            @(posedge clk); #1;
            if (c == rb_low) iRB_N = 1'b1;
            if (poke && c == 3) begin
                op_valid = 1'b1;
                op_type  = 2'b10;
                op_row   = 24'h777777;
            end
            if (poke && c == 4) op_valid = 1'b0;
        end
        iRB_N = 1'b1;
    endtask

    task automatic finish_op(input string tag, input logic err, input bit seen, input logic exp_err);
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_err"}, err, exp_err);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_width"}, op_done, 0);
        check({tag, "_ready_after"}, op_ready, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_q(input string tag, input logic [63:0] eb, input int nb,
                             input logic [255:0] ei, input int ni);
        logic [31:0] a;
        check({tag, "_nbytes"}, bq.size(), nb);
        for (int i = 0; i < nb; i++) begin
            a = (i < bq.size()) ? {24'h0, bq[i]} : 32'hDEADBEEF;
            check($sformatf("%s_byte%0d", tag, i), a, {24'h0, eb[63-8*i -: 8]});
        end
        check({tag, "_ninstr"}, iq.size(), ni);
        for (int i = 0; i < ni; i++) begin
            a = (i < iq.size()) ? iq[i] : 32'hDEADBEEF;
            check($sformatf("%s_instr%0d", tag, i), a, ei[255-32*i -: 32]);
        end
    endtask

    initial begin
        logic err;
        bit   seen;
        int   n;
        int   n_cmd;

        vecs[0] = '{2'b00, 24'h123456, 50, 1'b0, 64'h0000005634123000, 7,
                    {32'h1, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h1, 32'h07FF0004}, 8, 1'b0};
        vecs[1] = '{2'b01, 24'h00ABCD, 40, 1'b1, 64'h800000CDAB001000, 7,
                    {32'h1, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h07FF0003, 32'h1}, 8, 1'b0};
        vecs[2] = '{2'b10, 24'h000A01, 30, 1'b0, 64'h60010A00D0000000, 5,
                    {32'h1, 32'h2, 32'h2, 32'h2, 32'h1, 32'h0, 32'h0, 32'h0}, 5, 1'b0};
        vecs[3] = '{2'b11, 24'h555555, 25, 1'b0, 64'hFF00000000000000, 1,
                    {32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1, 1'b0};
        vecs[4] = '{2'b00, 24'h00BEEF, 5000, 1'b0, 64'h000000EFBE003000, 7,
                    {32'h1, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h1, 32'h0}, 7, 1'b1};

        rst        = 1'b0;
        op_valid   = 1'b0;
        op_type    = 2'b00;
        op_row     = 24'h0;
        instr_full = 1'b0;
        byte_full  = 1'b0;
        iRB_N      = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_op_ready", op_ready, 0);
        check("rst_op_done", op_done, 0);
        check("rst_op_err", op_err, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_instr_wr", instr_wr, 0);
        check("rst_byte_data", byte_data, 32'hAA);
        check("rst_byte_wr", byte_wr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready", op_ready, 1);
        check("post_rst_byte_data", byte_data, 32'hAA);

        // Reset asserted while a read is stalled in XFER
        start_op(2'b00, 24'h000001, 1'b0);
        for (int c = 0; c < 100 && bq.size() < 7; c++) @(posedge clk);
        #1 instr_full = 1'b1;
        repeat (20) @(negedge clk);
        check("xstall_instr", instr_data, 32'h07FF0004);
        check("xstall_instr_wr", instr_wr, 0);
        check("xstall_ready", op_ready, 0);
        check("xstall_ninstr", iq.size(), 7);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("xrst_op_ready", op_ready, 0);
        check("xrst_op_done", op_done, 0);
        check("xrst_op_err", op_err, 0);
        check("xrst_instr_data", instr_data, 0);
        check("xrst_instr_wr", instr_wr, 0);
        check("xrst_byte_data", byte_data, 32'hAA);
        check("xrst_byte_wr", byte_wr, 0);
        instr_full = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("xrst_ready_after", op_ready, 1);
        check("xrst_no_dout", iq.size(), 7);

        // Table-driven op vectors
        for (int v = 0; v < 5; v++) begin
            start_op(vecs[v].kind, vecs[v].row, 1'b1);
            wait_done(vecs[v].rb_low, vecs[v].poke, err, seen);
            finish_op($sformatf("vec%0d", v), err, seen, vecs[v].err);
            compare_q($sformatf("vec%0d", v), vecs[v].bytes, vecs[v].nb, vecs[v].instrs, vecs[v].ni);
        end

        // Erase with byte FIFO full at the second address byte
        start_op(2'b10, 24'h000A01, 1'b1);
        for (int c = 0; c < 50 && bq.size() < 2; c++) @(posedge clk);
        #1 byte_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("estall_byte", byte_data, 32'h0A);
            check("estall_byte_wr", byte_wr, 0);
            check("estall_instr_wr", instr_wr, 0);
        end
        @(posedge clk); #1;
        byte_full = 1'b0;
        wait_done(30, 1'b0, err, seen);
        finish_op("estall", err, seen, 1'b0);
        compare_q("estall", 64'h60010A00D0000000, 5,
                  {32'h1, 32'h2, 32'h2, 32'h2, 32'h1, 32'h0, 32'h0, 32'h0}, 5);

        // Chip reset with R/B# stuck busy: done exactly after tWB + timeout
        start_op(2'b11, 24'h0, 1'b1);
        n = 0;
        n_cmd = -1;
        seen = 1'b0;
        err = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            n++;
            if (instr_wr && n_cmd < 0) n_cmd = n;
            if (op_done) begin
                seen = 1'b1;
                err  = op_err;
                break;
            end
        end
        check("tmo_done_seen", seen, 1);
        check("tmo_latency", n - n_cmd, 1 + TWB + TIMEOUT);
        check("tmo_err", err, 1);
        @(negedge clk);
        check("tmo_done_width", op_done, 0);
        check("tmo_ready_after", op_ready, 1);
        iRB_N = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
